// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-back path: default geometry
// and the source indices used by the write-back arbiter.
package regfile_pkg;

  localparam int DEF_LOG_REG_CNT           = 2;
  localparam int DEF_LOG_SUPERSCALAR_WIDTH = 4;
  localparam int DEF_REG_WIDTH             = 288;
  localparam int ADDR_W                    = DEF_LOG_REG_CNT + DEF_LOG_SUPERSCALAR_WIDTH;

  localparam int NUM_SRC  = 3;
  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_DMA  = 2;

  // Source index arithmetic modulo NUM_SRC (operands are always < 3).
  function automatic logic [1:0] src_add(input logic [1:0] a, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Source handshake and register-file write ports of the write-back arbiter.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DEF_REG_WIDTH
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic [NUM_SRC*DW-1:0] src_data;
  logic                  port_c_we;
  logic                  port_d_we;
  logic [AW-1:0]         port_c_write_addr;
  logic [AW-1:0]         port_d_write_addr;
  logic [DW-1:0]         port_c_in;
  logic [DW-1:0]         port_d_in;
  logic                  empty;

  modport master (
    output src_valid, src_addr, src_data,
    input  src_ready, port_c_we, port_d_we, port_c_write_addr, port_d_write_addr,
           port_c_in, port_d_in, empty
  );

  modport slave (
    input  src_valid, src_addr, src_data,
    output src_ready, port_c_we, port_d_we, port_c_write_addr, port_d_write_addr,
           port_c_in, port_d_in, empty
  );
endinterface

// File: rtl/wb_fifo.sv
// Small in-order write-back queue; head is visible combinationally, no bypass.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left unreset; stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges three write-back sources into the two register-file write ports
// (C and D) with a round-robin priority and same-address conflict stalling.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int LOG_REG_CNT           = DEF_LOG_REG_CNT,
  parameter int LOG_SUPERSCALAR_WIDTH = DEF_LOG_SUPERSCALAR_WIDTH,
  parameter int REG_WIDTH             = DEF_REG_WIDTH,
  parameter int FIFO_DEPTH            = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = LOG_REG_CNT + LOG_SUPERSCALAR_WIDTH;
  localparam int EW = AW + REG_WIDTH;

  logic [NUM_SRC-1:0]   fifo_full;
  logic [NUM_SRC-1:0]   fifo_empty;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [EW-1:0]        head [NUM_SRC];
  logic [AW-1:0]        head_addr [NUM_SRC];
  logic [REG_WIDTH-1:0] head_data [NUM_SRC];

  logic [1:0] rr;
  logic [1:0] c_src;
  logic [1:0] d_src;
  logic [1:0] idx;
  logic       c_found;
  logic       d_found;
  logic       issue;

  assign bus.src_ready = ~fifo_full & {NUM_SRC{~freeze}};
  assign push          = bus.src_valid & bus.src_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   ({bus.src_addr[g*AW +: AW], bus.src_data[g*REG_WIDTH +: REG_WIDTH]}),
      .head  (head[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
    assign head_addr[g] = head[g][EW-1 -: AW];
    assign head_data[g] = head[g][REG_WIDTH-1:0];
  end

  // Port C takes the first non-empty queue in rr order; port D the next one
  // whose head targets a different register (same-address heads must wait).
  always_comb begin
    c_found = 1'b0;
    d_found = 1'b0;
    c_src   = rr;
    d_src   = rr;
    idx     = rr;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = src_add(rr, 2'(k));
      if (!fifo_empty[idx]) begin
        if (!c_found) begin
          c_found = 1'b1;
          c_src   = idx;
        end else if (!d_found && (head_addr[idx] != head_addr[c_src])) begin
          d_found = 1'b1;
          d_src   = idx;
        end
      end
    end
  end

  assign issue                 = c_found & ~freeze;
  assign bus.port_c_we         = issue;
  assign bus.port_d_we         = issue & d_found;
  assign bus.port_c_write_addr = head_addr[c_src];
  assign bus.port_d_write_addr = head_addr[d_src];
  assign bus.port_c_in         = head_data[c_src];
  assign bus.port_d_in         = head_data[d_src];
  assign bus.empty             = &fifo_empty;

  always_comb begin
    pop = '0;
    if (bus.port_c_we) pop[c_src] = 1'b1;
    if (bus.port_d_we) pop[d_src] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)      rr <= 2'd0;
    else if (issue) rr <= src_add(c_src, 2'd1);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued by the
// stimulus and consumed by an independent port monitor.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DW = DEF_REG_WIDTH;

  logic clk = 1'b0;
  logic reset;
  logic freeze;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .bus    (bus)
  );

  typedef struct {
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic port, input int addr, input int data);
    wr_t e;
    e.port = port;
    e.addr = ADDR_W'(addr);
    e.data = DW'(data);
    sb.push_back(e);
  endtask

  task automatic set_src(input int i, input int addr, input int data);
    bus.src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    bus.src_data[i*DW +: DW]         = DW'(data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    freeze        = 1'b0;
    bus.src_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk({name, "_drain_left"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk({name, "_empty"}, 32'(bus.empty), 32'd1);
    tick();
  endtask

  task automatic check_port(input logic port, input logic [ADDR_W-1:0] addr,
                            input logic [DW-1:0] data);
    wr_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_write port=%0d addr=%0h data=%0h required=none",
               port, addr, data);
    end else begin
      e = sb.pop_front();
      if (e.port !== port || e.addr !== addr || e.data !== data) begin
        failures++;
        $display("FAIL write port=%0d addr=%0h data=%0h required port=%0d addr=%0h data=%0h",
                 port, addr, data, e.port, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every asserted write enable must match the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.port_c_we === 1'b1)
        check_port(1'b0, bus.port_c_write_addr, bus.port_c_in);
      if (bus.port_d_we === 1'b1) begin
        if (bus.port_c_we !== 1'b1) chk("d_without_c", 32'(bus.port_c_we), 32'd1);
        check_port(1'b1, bus.port_d_write_addr, bus.port_d_in);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    freeze        = 1'b0;
    bus.src_valid = '0;
    bus.src_addr  = '0;
    bus.src_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_ready", 32'(bus.src_ready), 32'd7);
    chk("rst_we", 32'({bus.port_c_we, bus.port_d_we}), 32'd0);
    tick();

    // Single ALU write
    set_src(SRC_ALU, 5, 'hA);
    bus.src_valid = 3'b001;
    expect_wr(1'b0, 5, 'hA);
    tick();
    bus.src_valid = '0;
    @(negedge clk);
    chk("t1_not_empty", 32'(bus.empty), 32'd0);
    wait_drain("t1");

    // Dual-port write, then rr=1 puts the load unit on port C
    do_reset();
    set_src(SRC_ALU, 3, 'h31);
    set_src(SRC_LOAD, 7, 'h71);
    bus.src_valid = 3'b011;
    expect_wr(1'b0, 3, 'h31);
    expect_wr(1'b1, 7, 'h71);
    tick();
    bus.src_valid = '0;
    @(negedge clk);
    chk("t2_both_we", 32'({bus.port_c_we, bus.port_d_we}), 32'd3);
    tick();
    set_src(SRC_ALU, 1, 'h12);
    set_src(SRC_LOAD, 2, 'h22);
    bus.src_valid = 3'b011;
    expect_wr(1'b0, 2, 'h22);
    expect_wr(1'b1, 1, 'h12);
    tick();
    bus.src_valid = '0;
    wait_drain("t2");

    // Same-address conflict across all sources, DMA queue filled behind it
    do_reset();
    set_src(SRC_ALU, 9, 'h91);
    set_src(SRC_LOAD, 9, 'h92);
    set_src(SRC_DMA, 9, 'h93);
    bus.src_valid = 3'b111;
    expect_wr(1'b0, 9, 'h91);
    expect_wr(1'b0, 9, 'h92);
    expect_wr(1'b0, 9, 'h93);
    expect_wr(1'b0, 10, 'hA0);
    tick();
    set_src(SRC_DMA, 10, 'hA0);
    bus.src_valid = 3'b100;
    tick();
    set_src(SRC_DMA, 11, 'hB0);
    @(negedge clk);
    chk("t3_dma_full", 32'(bus.src_ready), 32'd3);
    chk("t3_conflict_no_d", 32'(bus.port_d_we), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_dma_full_pop", 32'(bus.src_ready[2]), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_dma_ready", 32'(bus.src_ready[2]), 32'd1);
    expect_wr(1'b0, 11, 'hB0);
    tick();
    bus.src_valid = '0;
    wait_drain("t3");

    // ALU stream across a three-cycle freeze
    do_reset();
    set_src(SRC_ALU, 1, 'h11);
    bus.src_valid = 3'b001;
    expect_wr(1'b0, 1, 'h11);
    expect_wr(1'b0, 2, 'h12);
    expect_wr(1'b0, 3, 'h13);
    tick();
    freeze = 1'b1;
    set_src(SRC_ALU, 2, 'h12);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_frz_ready", 32'(bus.src_ready), 32'd0);
      chk("t4_frz_we", 32'({bus.port_c_we, bus.port_d_we}), 32'd0);
      tick();
    end
    freeze = 1'b0;
    tick();
    set_src(SRC_ALU, 3, 'h13);
    tick();
    bus.src_valid = '0;
    wait_drain("t4");

    // Reset with queued entries discards them and clears rr
    do_reset();
    set_src(SRC_ALU, 12, 'hC1);
    bus.src_valid = 3'b001;
    expect_wr(1'b0, 12, 'hC1);
    tick();
    bus.src_valid = '0;
    wait_drain("t6a");
    set_src(SRC_ALU, 13, 'hD1);
    set_src(SRC_DMA, 14, 'hD2);
    bus.src_valid = 3'b101;
    tick();
    bus.src_valid = '0;
    freeze = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    chk("t6_frz_we", 32'({bus.port_c_we, bus.port_d_we}), 32'd0);
    tick();
    reset  = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_ready", 32'(bus.src_ready), 32'd7);
    chk("t6_rst_we", 32'({bus.port_c_we, bus.port_d_we}), 32'd0);
    tick();
    set_src(SRC_ALU, 15, 'hE1);
    set_src(SRC_DMA, 16, 'hE2);
    bus.src_valid = 3'b101;
    expect_wr(1'b0, 15, 'hE1);
    expect_wr(1'b1, 16, 'hE2);
    tick();
    bus.src_valid = '0;
    wait_drain("t6");

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
